// File: rtl/rv_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM state encoding, the canonical NOP,
// the reset PC and the saturating stall-count step.
package rv_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_TMO   = 2'd3
  } pipe_state_t;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // Clearing wins over counting; a clear with enable lands on 1 (first stall cycle).
  function automatic logic [7:0] scnt_next(input logic [7:0] cnt, input logic clr,
                                           input logic en);
    if (clr) return {7'd0, en};
    if (en && (cnt != 8'hFF)) return cnt + 8'd1;
    return cnt;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/control bundle between the pipeline (master) and pipe_ctrl (slave).
// Level-sensitive strobes sampled every cycle; no valid/ready handshake is involved.
interface pipe_ctrl_if #(parameter int ADDR_W = 32);
  logic              jump_en_i;
  logic [ADDR_W-1:0] jump_addr_i;
  logic              hold_req_i;
  logic              bus_wait_i;
  logic              jump_en_o;
  logic [ADDR_W-1:0] jump_addr_o;
  logic              hold_pc_o;
  logic              hold_if_id_o;
  logic              hold_id_ex_o;
  logic              flush_if_id_o;
  logic              flush_id_ex_o;
  logic [1:0]        state_o;
  logic              timeout_o;

  modport master (
    output jump_en_i, jump_addr_i, hold_req_i, bus_wait_i,
    input  jump_en_o, jump_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
           flush_if_id_o, flush_id_ex_o, state_o, timeout_o
  );

  modport slave (
    input  jump_en_i, jump_addr_i, hold_req_i, bus_wait_i,
    output jump_en_o, jump_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
           flush_if_id_o, flush_id_ex_o, state_o, timeout_o
  );
endinterface

// File: rtl/pipe_ctrl_stall_timer.sv
// 8-bit saturating stall counter with clear/enable and terminal-count compare.
module pipe_ctrl_stall_timer
  import rv_ctrl_pkg::*;
#(
  parameter int TC = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [7:0] cnt,
  output logic       tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= scnt_next(cnt, clr, en);
  end

  assign tc = (cnt == 8'(TC));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/squash controller for the RV32I core.
// Optional stall watchdog enabled by defining PIPE_CTRL_TIMEOUT_EN.
module pipe_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int FLUSH_DEPTH = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  pipe_ctrl_if.slave ctl
);

  localparam logic [2:0] FD_M1 = 3'(FLUSH_DEPTH - 1);

  pipe_state_t       st, nxt;
  logic [2:0]        fcnt, fcnt_n;
  logic [7:0]        scnt;
  logic              s_clr, s_en, s_tc, tmo_set, tmo_flag;
  logic              jmp, hpc, hifid, hidex, fifid, fidex;
  logic [ADDR_W-1:0] addr;
  logic              unused_scnt;

  assign addr        = ctl.jump_addr_i;
  assign unused_scnt = ^scnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ST_RUN;
      fcnt     <= '0;
      tmo_flag <= 1'b0;
    end else begin
      st       <= nxt;
      fcnt     <= fcnt_n;
      tmo_flag <= tmo_flag | tmo_set;
    end
  end

`ifdef PIPE_CTRL_TIMEOUT_EN
  pipe_ctrl_stall_timer #(.TC(TIMEOUT_CYC)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (s_clr),
    .en   (s_en),
    .cnt  (scnt),
    .tc   (s_tc)
  );
`else
  localparam int unused_tmo_cyc = TIMEOUT_CYC;
  assign s_tc = 1'b0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scnt <= '0;
    else        scnt <= scnt_next(scnt, s_clr, s_en);
  end
`endif

  // Priority: redirect, then stall request, then fetch wait.
  always_comb begin
    nxt     = st;
    fcnt_n  = fcnt;
    s_clr   = 1'b0;
    s_en    = 1'b0;
    tmo_set = 1'b0;
    jmp     = 1'b0;
    hpc     = 1'b0;
    hifid   = 1'b0;
    hidex   = 1'b0;
    fifid   = 1'b0;
    fidex   = 1'b0;
    if (ctl.jump_en_i) begin
      jmp    = 1'b1;
      fifid  = 1'b1;
      fidex  = 1'b1;
      fcnt_n = FD_M1;
      s_clr  = 1'b1;
      nxt    = (FLUSH_DEPTH > 1) ? ST_FLUSH : ST_RUN;
    end else begin
      case (st)
        ST_RUN, ST_STALL: begin
          if (ctl.hold_req_i) begin
            hpc   = 1'b1;
            hifid = 1'b1;
            hidex = 1'b1;
            s_en  = 1'b1;
            if (st == ST_RUN) begin
              s_clr = 1'b1;
              nxt   = ST_STALL;
            end else if (s_tc) begin
              s_en    = 1'b0;
              s_clr   = 1'b1;
              tmo_set = 1'b1;
              nxt     = ST_TMO;
            end
          end else begin
            s_clr = 1'b1;
            nxt   = ST_RUN;
            if (ctl.bus_wait_i) begin
              hpc   = 1'b1;
              fifid = 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          // ex already holds a NOP here, so a stall request has nothing to hold.
          fifid = 1'b1;
          hpc   = ctl.bus_wait_i;
          if (fcnt <= 3'd1) begin
            fcnt_n = '0;
            nxt    = ST_RUN;
          end else begin
            fcnt_n = fcnt - 3'd1;
          end
        end
        default: begin
          fifid = 1'b1;
          fidex = 1'b1;
          nxt   = ST_RUN;
        end
      endcase
    end
  end

  assign ctl.jump_en_o     = rst_n & jmp;
  assign ctl.jump_addr_o   = (rst_n && jmp) ? addr : '0;
  assign ctl.hold_pc_o     = rst_n & hpc;
  assign ctl.hold_if_id_o  = rst_n & hifid;
  assign ctl.hold_id_ex_o  = rst_n & hidex;
  assign ctl.flush_if_id_o = rst_n & fifid;
  assign ctl.flush_id_ex_o = rst_n & fidex;
  assign ctl.state_o       = rst_n ? st : 2'd0;
  assign ctl.timeout_o     = rst_n & tmo_flag;

endmodule
